// File: rtl/saturn_run_ctrl.sv
// saturn_run_ctrl -- run controller for the Saturn core.
// Holds the core in reset for RESET_CYCLES edges after a synchronised reset
// release, counts run cycles (saturating), latches halt requests into a sticky
// vector and declares completion, optionally after a drain period. A restart
// pulse in DONE begins a fresh run.
// Optional feature macro: SATURN_RUN_WATCHDOG_EN (ends a run with o_timeout=1
// once the cycle count reaches MAX_CYCLES).
module saturn_run_ctrl #(
  parameter int RESET_CYCLES = 3,
  parameter int N_HALT       = 1,
  parameter int HALT_ALL     = 0,
  parameter int DRAIN_CYCLES = 0,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_HALT-1:0] i_halt,
  input  logic              i_restart,
  output logic              o_core_reset,
  output logic              o_running,
  output logic              o_done,
  output logic [N_HALT-1:0] o_halt_vec,
  output logic [CNT_W-1:0]  o_cycles,
  output logic              o_timeout
);

  localparam int HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_RST_HOLD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d, cycles_inc;
  logic [N_HALT-1:0]   halt_vec_q, halt_vec_d, halt_vec_upd;
  logic                rst_sync;
  logic                halt_hit;
  logic                wd_hit;
  logic                wd_fire;
  logic                restart_fire;

  assign rst_sync = sync_q[1];

  // Two-flop synchroniser: assertion is asynchronous, release is aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the chain.
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  // Saturating increment and the halt vector as it would look after this edge.
  assign cycles_inc   = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
  assign halt_vec_upd = halt_vec_q | i_halt;
  assign halt_hit     = (HALT_ALL != 0) ? (&halt_vec_upd) : (|halt_vec_upd);

`ifdef SATURN_RUN_WATCHDOG_EN
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
  assign wd_hit = (cycles_inc >= MAX_C);
`else
  assign wd_hit = 1'b0;
`endif

  // Next-state and datapath updates for the run sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    hold_d       = hold_q;
    drain_d      = drain_q;
    cycles_d     = cycles_q;
    halt_vec_d   = halt_vec_q;
    wd_fire      = 1'b0;
    restart_fire = 1'b0;

    unique case (state_q)
      S_RST_HOLD: begin
        if (rst_sync) begin
          if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
            state_d = S_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      S_RUN: begin
        cycles_d   = cycles_inc;
        halt_vec_d = halt_vec_upd;
        drain_d    = '0;
        // A halt on the same edge as the watchdog limit takes priority.
        if (halt_hit) begin
          state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;
        end else if (wd_hit) begin
          state_d = S_DONE;
          wd_fire = 1'b1;
        end
      end

      S_DRAIN: begin
        cycles_d   = cycles_inc;
        halt_vec_d = halt_vec_upd;
        if (drain_q == DRAIN_W'(DRAIN_LAST)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
          if (wd_hit) begin
            state_d = S_DONE;
            wd_fire = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (i_restart) begin
          state_d      = S_RST_HOLD;
          hold_d       = '0;
          drain_d      = '0;
          cycles_d     = '0;
          halt_vec_d   = '0;
          restart_fire = 1'b1;
        end
      end

      default: state_d = S_RST_HOLD;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_RST_HOLD;
      hold_q     <= '0;
      drain_q    <= '0;
      cycles_q   <= '0;
      halt_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      drain_q    <= drain_d;
      cycles_q   <= cycles_d;
      halt_vec_q <= halt_vec_d;
    end
  end

`ifdef SATURN_RUN_WATCHDOG_EN
  logic timeout_q;

  // Sticky timeout flag, cleared only by reset or restart.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      timeout_q <= 1'b0;
    end else if (restart_fire) begin
      timeout_q <= 1'b0;
    end else if (wd_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Watchdog compiled out: the limit parameter and its strobes have no effect.
  logic unused_watchdog;
  assign unused_watchdog = wd_fire ^ restart_fire ^ (^32'(MAX_CYCLES));
  assign o_timeout       = 1'b0;
`endif

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign o_core_reset = (state_q == S_RST_HOLD) || (state_q == S_DONE);
  assign o_running    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign o_done       = (state_q == S_DONE);
  assign o_halt_vec   = halt_vec_q;
  assign o_cycles     = cycles_q;

endmodule

// File: tb/tb_saturn_run_ctrl.sv
// Directed bench for saturn_run_ctrl. Six instances cover the default build,
// all-bits and any-bit halting on two channels, a drain period with restart
// and mid-drain async reset, and a 4-bit counter with MAX_CYCLES=8 (saturation
// or watchdog depending on SATURN_RUN_WATCHDOG_EN).
module tb_saturn_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // u0: defaults
  logic rst0, halt0, restart0;
  logic cr0, run0, done0, hv0, to0;
  logic [31:0] cyc0;
  saturn_run_ctrl u0 (
    .i_clk(clk), .i_reset(rst0), .i_halt(halt0), .i_restart(restart0),
    .o_core_reset(cr0), .o_running(run0), .o_done(done0),
    .o_halt_vec(hv0), .o_cycles(cyc0), .o_timeout(to0)
  );

  // u1: two channels, all bits required
  logic rst1, restart1;
  logic [1:0] halt1, hv1;
  logic cr1, run1, done1, to1;
  logic [31:0] cyc1;
  saturn_run_ctrl #(.N_HALT(2), .HALT_ALL(1)) u1 (
    .i_clk(clk), .i_reset(rst1), .i_halt(halt1), .i_restart(restart1),
    .o_core_reset(cr1), .o_running(run1), .o_done(done1),
    .o_halt_vec(hv1), .o_cycles(cyc1), .o_timeout(to1)
  );

  // u2: two channels, any bit
  logic rst2, restart2;
  logic [1:0] halt2, hv2;
  logic cr2, run2, done2, to2;
  logic [31:0] cyc2;
  saturn_run_ctrl #(.N_HALT(2), .HALT_ALL(0)) u2 (
    .i_clk(clk), .i_reset(rst2), .i_halt(halt2), .i_restart(restart2),
    .o_core_reset(cr2), .o_running(run2), .o_done(done2),
    .o_halt_vec(hv2), .o_cycles(cyc2), .o_timeout(to2)
  );

  // u3: four drain cycles
  logic rst3, halt3, restart3;
  logic cr3, run3, done3, hv3, to3;
  logic [31:0] cyc3;
  saturn_run_ctrl #(.DRAIN_CYCLES(4)) u3 (
    .i_clk(clk), .i_reset(rst3), .i_halt(halt3), .i_restart(restart3),
    .o_core_reset(cr3), .o_running(run3), .o_done(done3),
    .o_halt_vec(hv3), .o_cycles(cyc3), .o_timeout(to3)
  );

  // u4: 4-bit counter, limit 8, never halted
  logic rst4, halt4, restart4;
  logic cr4, run4, done4, hv4, to4;
  logic [3:0] cyc4;
  saturn_run_ctrl #(.CNT_W(4), .MAX_CYCLES(8)) u4 (
    .i_clk(clk), .i_reset(rst4), .i_halt(halt4), .i_restart(restart4),
    .o_core_reset(cr4), .o_running(run4), .o_done(done4),
    .o_halt_vec(hv4), .o_cycles(cyc4), .o_timeout(to4)
  );

  // u5: 4-bit counter, limit 8, halt on the limit edge
  logic rst5, halt5, restart5;
  logic cr5, run5, done5, hv5, to5;
  logic [3:0] cyc5;
  saturn_run_ctrl #(.CNT_W(4), .MAX_CYCLES(8)) u5 (
    .i_clk(clk), .i_reset(rst5), .i_halt(halt5), .i_restart(restart5),
    .o_core_reset(cr5), .o_running(run5), .o_done(done5),
    .o_halt_vec(hv5), .o_cycles(cyc5), .o_timeout(to5)
  );

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0; rst5 = 1'b0;
    halt0 = 1'b0; halt1 = 2'b00; halt2 = 2'b00; halt3 = 1'b0; halt4 = 1'b0; halt5 = 1'b0;
    restart0 = 1'b0; restart1 = 1'b0; restart2 = 1'b0;
    restart3 = 1'b0; restart4 = 1'b0; restart5 = 1'b0;
    step(2);

    // ---- u0: reset values, hold sequence, halt at cycle 10, restart ----
    check("rst_core_reset", 32'(cr0), 1);
    check("rst_running", 32'(run0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_halt_vec", 32'(hv0), 0);
    check("rst_cycles", cyc0, 0);
    check("rst_timeout", 32'(to0), 0);

    rst0 = 1'b1;
    step(2);  // synchroniser released
    check("sync_core_reset", 32'(cr0), 1);
    step(2);  // two hold edges
    check("hold2_core_reset", 32'(cr0), 1);
    check("hold2_running", 32'(run0), 0);
    step(1);  // third hold edge -> RUN
    check("run_core_reset", 32'(cr0), 0);
    check("run_running", 32'(run0), 1);
    check("run_cycles0", cyc0, 0);
    step(1);
    check("run_cycles1", cyc0, 1);
    step(2);
    check("run_cycles3", cyc0, 3);
    restart0 = 1'b1;  // ignored while running
    step(1);
    restart0 = 1'b0;
    check("restart_in_run_running", 32'(run0), 1);
    check("restart_in_run_cycles", cyc0, 4);
    step(6);
    check("run_cycles10", cyc0, 10);
    halt0 = 1'b1;
    step(1);
    halt0 = 1'b0;
    check("halt_done", 32'(done0), 1);
    check("halt_cycles", cyc0, 11);
    check("halt_vec", 32'(hv0), 1);
    check("halt_core_reset", 32'(cr0), 1);
    check("halt_running", 32'(run0), 0);
    halt0 = 1'b1;  // later halts ignored
    step(3);
    halt0 = 1'b0;
    check("done_hold_cycles", cyc0, 11);
    check("done_hold_done", 32'(done0), 1);
    restart0 = 1'b1;
    step(1);
    restart0 = 1'b0;
    check("restart_done", 32'(done0), 0);
    check("restart_cycles", cyc0, 0);
    check("restart_vec", 32'(hv0), 0);
    check("restart_core_reset", 32'(cr0), 1);
    step(2);
    check("restart_hold_core_reset", 32'(cr0), 1);
    step(1);
    check("restart_run_running", 32'(run0), 1);
    step(2);
    check("restart_run_cycles", cyc0, 2);

    // ---- u1: all-bits halting, bit0 pulse at 5, bit1 at 9 ----
    rst1 = 1'b1;
    step(5);
    check("all_running", 32'(run1), 1);
    step(5);
    check("all_cycles5", cyc1, 5);
    halt1 = 2'b01;
    step(1);
    halt1 = 2'b00;
    check("all_bit0_done", 32'(done1), 0);
    check("all_bit0_vec", 32'(hv1), 1);
    step(3);
    check("all_cycles9", cyc1, 9);
    check("all_still_running", 32'(run1), 1);
    halt1 = 2'b10;
    step(1);
    halt1 = 2'b00;
    check("all_done", 32'(done1), 1);
    check("all_vec", 32'(hv1), 3);
    check("all_cycles", cyc1, 10);

    // ---- u2: any-bit halting ----
    rst2 = 1'b1;
    step(10);
    check("any_cycles5", cyc2, 5);
    halt2 = 2'b01;
    step(1);
    halt2 = 2'b00;
    check("any_done", 32'(done2), 1);
    check("any_vec", 32'(hv2), 1);
    check("any_cycles", cyc2, 6);

    // ---- u3: drain, restart, mid-drain async reset ----
    rst3 = 1'b1;
    step(25);
    check("drain_cycles20", cyc3, 20);
    halt3 = 1'b1;
    step(1);
    halt3 = 1'b0;
    check("drain_enter_running", 32'(run3), 1);
    check("drain_enter_done", 32'(done3), 0);
    check("drain_enter_cycles", cyc3, 21);
    step(3);
    check("drain_mid_done", 32'(done3), 0);
    check("drain_mid_cycles", cyc3, 24);
    step(1);
    check("drain_done", 32'(done3), 1);
    check("drain_cycles", cyc3, 25);
    check("drain_running", 32'(run3), 0);
    restart3 = 1'b1;
    step(1);
    restart3 = 1'b0;
    check("drain_restart_cycles", cyc3, 0);
    check("drain_restart_done", 32'(done3), 0);
    step(3);
    check("drain_rerun_running", 32'(run3), 1);
    step(2);
    halt3 = 1'b1;
    step(1);
    halt3 = 1'b0;
    step(1);
    check("drain2_running", 32'(run3), 1);
    check("drain2_cycles", cyc3, 4);
    #2;
    rst3 = 1'b0;  // between edges: no clock follows before the checks
    #1;
    check("async_core_reset", 32'(cr3), 1);
    check("async_running", 32'(run3), 0);
    check("async_done", 32'(done3), 0);
    check("async_vec", 32'(hv3), 0);
    check("async_cycles", cyc3, 0);
    check("async_timeout", 32'(to3), 0);

    // ---- u4: saturation or watchdog ----
    rst4 = 1'b1;
    step(5);
    step(8);
    check("wd_cycles8", 32'(cyc4), 8);
`ifdef SATURN_RUN_WATCHDOG_EN
    check("wd_done", 32'(done4), 1);
    check("wd_timeout", 32'(to4), 1);
    step(12);
    check("wd_hold_cycles", 32'(cyc4), 8);
    check("wd_hold_timeout", 32'(to4), 1);
    restart4 = 1'b1;
    step(1);
    restart4 = 1'b0;
    check("wd_restart_timeout", 32'(to4), 0);
`else
    check("sat_running8", 32'(run4), 1);
    check("sat_timeout", 32'(to4), 0);
    step(12);
    check("sat_cycles", 32'(cyc4), 15);
    check("sat_running", 32'(run4), 1);
`endif

    // ---- u5: halt on the limit edge wins ----
    rst5 = 1'b1;
    step(12);
    check("tie_cycles7", 32'(cyc5), 7);
    halt5 = 1'b1;
    step(1);
    halt5 = 1'b0;
    check("tie_done", 32'(done5), 1);
    check("tie_cycles", 32'(cyc5), 8);
    check("tie_timeout", 32'(to5), 0);
    check("tie_vec", 32'(hv5), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
